// File: rtl/lc3_pkg.sv
// Shared opcode encodings, memory-access state type and instruction
// classification helpers for the LC-3 pipeline controller.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef enum logic [1:0] {
      MEM_READ  = 2'd0,
      MEM_WRITE = 2'd1,
      MEM_IND   = 2'd2,
      MEM_IDLE  = 2'd3
   } mem_state_t;

   function automatic logic is_alu(input logic [15:0] instr);
      return instr[15:12] inside {OP_ADD, OP_AND, OP_NOT};
   endfunction

   function automatic logic writes_reg(input logic [15:0] instr);
      return is_alu(instr) || (instr[15:12] == OP_LEA);
   endfunction

   function automatic logic is_load(input logic [15:0] instr);
      return instr[15:12] inside {OP_LD, OP_LDR, OP_LDI};
   endfunction

   function automatic logic is_store(input logic [15:0] instr);
      return instr[15:12] inside {OP_ST, OP_STR, OP_STI};
   endfunction

   function automatic logic is_indirect(input logic [15:0] instr);
      return instr[15:12] inside {OP_LDI, OP_STI};
   endfunction

   function automatic logic is_branch(input logic [15:0] instr);
      return instr[15:12] inside {OP_BR, OP_JMP};
   endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory access sequencer: IDLE/READ/WRITE/IND_READ with a stall flag
// and a pulse marking the cycle a load result is committed.
module lc3_mem_fsm
   import lc3_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        exec_go,
   input  logic [15:0] ir_exec,
   input  logic        complete_data,
   output mem_state_t  mem_state,
   output logic        mem_stall,
   output logic        load_done
);

   mem_state_t state, state_next;
   logic       ind_store, ind_store_next;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= MEM_IDLE;
         ind_store <= 1'b0;
      end else begin
         state     <= state_next;
         ind_store <= ind_store_next;
      end
   end

   // The indirect second phase is chosen from a flag latched on entry, so the
   // execute-stage IR may change while the access is in flight.
   always_comb begin
      state_next     = state;
      ind_store_next = ind_store;
      load_done      = 1'b0;
      case (state)
         MEM_IDLE: begin
            if (exec_go) begin
               if (is_indirect(ir_exec)) begin
                  state_next     = MEM_IND;
                  ind_store_next = is_store(ir_exec);
               end else if (is_load(ir_exec)) begin
                  state_next = MEM_READ;
               end else if (is_store(ir_exec)) begin
                  state_next = MEM_WRITE;
               end
            end
         end
         MEM_IND: begin
            if (complete_data) state_next = ind_store ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            if (complete_data) begin
               state_next = MEM_IDLE;
               load_done  = 1'b1;
            end
         end
         MEM_WRITE: begin
            if (complete_data) state_next = MEM_IDLE;
         end
      endcase
   end

   assign mem_state = state;
   assign mem_stall = (state != MEM_IDLE);

endmodule

// File: rtl/lc3_pipeline_ctrl.sv
// LC-3 five-stage pipeline sequencer: stage enables, branch bubble insertion,
// branch-taken select and ALU/memory operand bypass selects.
module lc3_pipeline_ctrl
   import lc3_pkg::*;
#(
   parameter int unsigned BR_BUBBLES = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        complete_instr,
   input  logic        complete_data,
   input  logic [15:0] IR,
   input  logic [15:0] IR_Exec,
   input  logic [2:0]  NZP,
   output logic        enable_updatePC,
   output logic        enable_fetch,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        br_taken,
   output logic        bypass_alu_1,
   output logic        bypass_alu_2,
   output logic        bypass_mem_1,
   output logic        bypass_mem_2,
   output logic [1:0]  mem_state
);

   logic [3:0] stage_valid;
   logic [2:0] bubble_cnt;
   logic [2:0] mem_dest;
   logic       mem_dest_valid;
   logic       mem_stall, load_done, advance;
   mem_state_t mem_state_q;

   lc3_mem_fsm u_mem_fsm (
      .clock         (clock),
      .reset         (reset),
      .exec_go       (enable_execute),
      .ir_exec       (IR_Exec),
      .complete_data (complete_data),
      .mem_state     (mem_state_q),
      .mem_stall     (mem_stall),
      .load_done     (load_done)
   );

   assign mem_state = mem_state_q;
   // Instruction-memory wait only stalls while no data access is pending.
   assign advance   = complete_instr && !mem_stall;

   always_comb begin
      enable_fetch     = advance && stage_valid[0] && (bubble_cnt == '0);
      enable_updatePC  = advance && stage_valid[0] && (bubble_cnt <= 3'd1);
      enable_decode    = advance && stage_valid[1];
      enable_execute   = advance && stage_valid[2];
      enable_writeback = load_done || (advance && stage_valid[3]);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         stage_valid    <= '0;
         bubble_cnt     <= '0;
         mem_dest       <= '0;
         mem_dest_valid <= 1'b0;
      end else if (advance) begin
         stage_valid <= {stage_valid[2:0], 1'b1};
         if (bubble_cnt != '0)
            bubble_cnt <= bubble_cnt - 3'd1;
         else if (enable_decode && is_branch(IR))
            bubble_cnt <= 3'(BR_BUBBLES);
         if (enable_execute && is_load(IR_Exec)) begin
            mem_dest       <= IR_Exec[11:9];
            mem_dest_valid <= 1'b1;
         end else if (enable_decode) begin
            mem_dest_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      br_taken = 1'b0;
      if (stage_valid[2]) begin
         if (IR_Exec[15:12] == OP_JMP)
            br_taken = 1'b1;
         else if (IR_Exec[15:12] == OP_BR)
            br_taken = |(IR_Exec[11:9] & NZP);
      end
   end

   logic       uses_sr1, uses_sr2, exec_wr;
   logic       alu_hit_1, alu_hit_2, mem_hit_1, mem_hit_2;
   logic [2:0] sr2;

   // A store's data register (IR[11:9]) rides on the second operand path.
   always_comb begin
      uses_sr1 = IR[15:12] inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP};
      uses_sr2 = is_store(IR) || ((IR[15:12] inside {OP_ADD, OP_AND}) && !IR[5]);
      sr2      = is_store(IR) ? IR[11:9] : IR[2:0];
      exec_wr  = stage_valid[2] && writes_reg(IR_Exec);

      alu_hit_1 = stage_valid[1] && uses_sr1 && exec_wr && (IR_Exec[11:9] == IR[8:6]);
      alu_hit_2 = stage_valid[1] && uses_sr2 && exec_wr && (IR_Exec[11:9] == sr2);
      mem_hit_1 = stage_valid[1] && uses_sr1 && mem_dest_valid && (mem_dest == IR[8:6]);
      mem_hit_2 = stage_valid[1] && uses_sr2 && mem_dest_valid && (mem_dest == sr2);

      bypass_alu_1 = alu_hit_1;
      bypass_alu_2 = alu_hit_2;
      bypass_mem_1 = mem_hit_1 && !alu_hit_1;
      bypass_mem_2 = mem_hit_2 && !alu_hit_2;
   end

endmodule

// File: doc/lc3_pipeline_ctrl.md
Name: lc3_pipeline_ctrl

Overview:
Central sequencer for the LC-3 five-stage pipeline (fetch, decode, execute, memory access, writeback).
- Generates per-stage enables, the memory-access state, branch-taken and ALU/memory bypass selects.
- Sits beside the decode and execute stages. Consumes their IR copies plus the NZP flags and the memory completion strobes.
- Stalls the pipe for memory operations, control hazards and instruction-memory wait.

Parameters:
BR_BUBBLES, 3, fetch-stall cycles inserted after a BR/JMP is decoded (range 2..7).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
complete_instr  input  1  instruction memory returned data this cycle
complete_data  input  1  data memory access finished this cycle
IR  input  16  instruction in decode stage (decode output register)
IR_Exec  input  16  instruction in execute stage
NZP  input  3  condition codes from writeback
enable_updatePC  output  1  PC register load enable
enable_fetch  output  1  fetch stage enable
enable_decode  output  1  decode stage enable
enable_execute  output  1  execute stage enable
enable_writeback  output  1  writeback stage enable
br_taken  output  1  PC mux select: branch/jump target
bypass_alu_1  output  1  execute SR1 operand from execute result
bypass_alu_2  output  1  execute SR2 operand from execute result
bypass_mem_1  output  1  execute SR1 operand from memory read data
bypass_mem_2  output  1  execute SR2 operand from memory read data
mem_state  output  2  0=READ, 1=WRITE, 2=IND_READ, 3=IDLE

Behaviour:
Opcodes (IR[15:12]):
- ADD 0001, AND 0101, NOT 1001, LEA 1110
- LD 0010, LDR 0110, LDI 1010
- ST 0011, STR 0111, STI 1011
- BR 0000, JMP 1100

Reset (reset==0 at posedge):
- All enables 0, bypasses 0, br_taken 0, mem_state 3.
- Stage-valid shift register cleared.
- Reset mid-operation aborts any memory or branch stall immediately.

Start-up:
- Cycle 1 after release: enable_updatePC=enable_fetch=1.
- enable_decode rises cycle 2, enable_execute cycle 3, enable_writeback cycle 4.
- Enables are driven by a 4-bit stage-valid shift register.

Instruction stall:
- complete_instr==0 with mem_state==3: all five enables 0 that cycle; internal state frozen.

Memory FSM (registered mem_state):
- IDLE→READ: execute-stage instr is LD/LDR and enable_execute=1.
- IDLE→WRITE: ST/STR.
- IDLE→IND_READ: LDI/STI.
- IND_READ → READ (LDI) or WRITE (STI) on complete_data.
- READ/WRITE → IDLE on complete_data.
- While mem_state!=3: enable_updatePC/fetch/decode/execute = 0.
- enable_writeback=1 only in the cycle the final READ sees complete_data (load result committed); 0 for stores.
- complete_data while IDLE is ignored.

Control hazard:
- Decode-stage IR is BR/JMP with enable_decode=1: enable_updatePC and enable_fetch drop next cycle and stay low BR_BUBBLES cycles (down-counter).
- Decode, execute and writeback continue draining.
- br_taken is combinational, valid only while the branch is in execute:
  - JMP → 1.
  - BR → |(IR_Exec[11:9] & NZP).
  - Otherwise 0.
- BR with nzp=000 is never taken.
- Final bubble cycle: enable_updatePC=1 so the PC loads the target or PC+1.
- Following cycle: enable_fetch resumes.
- A memory stall during a branch stall freezes the bubble counter.

Bypass (combinational, registered inputs):
- Exec dest = IR_Exec[11:9] when IR_Exec is ADD/AND/NOT/LEA.
- bypass_alu_1 = exec dest == IR[8:6] and IR op in {ADD, AND, NOT, LDR, STR, JMP}.
- bypass_alu_2 = exec dest == IR[2:0], IR is ADD/AND, IR[5]==0.
- ST/STR/STI source IR[11:9] matching exec dest also asserts bypass_alu_2.
- bypass_mem_1/2: same compares against an internal IR_Mem register, where IR_Mem is the last execute-stage LD/LDR/LDI; cleared after one decode advance.
- alu has priority over mem when both match.
- All bypasses are 0 when the corresponding stage is not valid.

Decomposition:
- Package lc3_pkg: opcode localparams, mem_state enum (MEM_READ, MEM_WRITE, MEM_IND, MEM_IDLE), helper functions is_alu / is_load / is_store / writes_reg.
- Sub-module lc3_mem_fsm: the 4-state memory FSM with its stall output.
- Enables, branch counter and bypass logic stay in the top level.

Test Plan:
- Reset held 2 cycles, released, IR=ADD stream → fetch/updatePC=1 at cycle 1, decode cycle 2, execute cycle 3, writeback cycle 4; mem_state=3 throughout.
- IR_Exec=LDI (16'hA200), complete_data after 2 then 3 cycles → mem_state 3→2→0→3. Fetch/decode/execute are 0 for 5 cycles. enable_writeback=1 exactly once, in the final READ completion cycle.
- IR=BR nzp=010 (16'h0405), NZP=3'b010 → fetch low 3 cycles, br_taken=1 while in execute, updatePC=1 on the 3rd bubble. Repeat with NZP=3'b100 → br_taken=0.
- IR_Exec=ADD R3 (16'h1642), IR=ADD R1,R3,R3 (16'h12C3) → bypass_alu_1=1, bypass_alu_2=1. Same with IR[5]=1 → bypass_alu_2=0.
- IR_Exec=LD R2 then IR=NOT R4,R2 (16'h98BF) → bypass_mem_1=1, bypass_alu_1=0.
- Reset asserted while mem_state=0 → next cycle mem_state=3, all enables 0, branch counter cleared.
